// File: rtl/riscv_register_file_mp_pkg.sv
// Shared configuration for the multi-port RV32 integer register file.
// Holds the default data width, register count and address width, and the
// address legality helper used by the storage and the scoreboard.
// The read bypass switch RISCV_REGFILE_BYPASS_EN is a build-level define.
// It is normally set in riscv_configs.v and is not part of this package.
package riscv_register_file_mp_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_AW    = 5;

  // An address is live when it is nonzero and below the register count.
  // x0 and out-of-range addresses read as 0, are never pending, and
  // ignore writes and issues.
  function automatic logic rf_addr_ok(input logic [31:0] addr, input int unsigned nregs);
    return (addr != '0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Per-register pending scoreboard used for issue-stage WAW hazard detection.
// Ports:
//   i_clk, i_rstn         clock; asynchronous active-low reset clears all pending bits
//   i_wr_en/addr/clr      writeback ports; clr drops the pending bit of the address
//   i_iss_valid, i_iss_rd issue of an instruction that will write i_iss_rd
//   o_iss_ready           combinational: destination is not pending
//   o_busy_vec            full pending vector
module riscv_regfile_scoreboard
  import riscv_register_file_mp_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned AW    = RF_AW,
  parameter int unsigned NWR   = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic [NWR-1:0]    i_wr_clr,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rd,
  output logic              o_iss_ready,
  output logic [NREGS-1:0]  o_busy_vec
);

  localparam int unsigned IW = $clog2(NREGS);

  logic [NREGS-1:0] pend;
  logic             iss_ok;

  always_comb begin
    iss_ok      = rf_addr_ok(32'(i_iss_rd), NREGS);
    o_iss_ready = !(iss_ok && pend[i_iss_rd[IW-1:0]]);
  end

  // Later loop iterations override earlier ones, so the highest write port
  // decides the clear. A port without clr restores the old bit. The issue
  // set comes last, so a new producer stays pending over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && rf_addr_ok(32'(i_wr_addr[j*AW +: AW]), NREGS))
          pend[i_wr_addr[j*AW +: IW]] <= pend[i_wr_addr[j*AW +: IW]] & ~i_wr_clr[j];
      end
      if (i_iss_valid && o_iss_ready && iss_ok)
        pend[i_iss_rd[IW-1:0]] <= 1'b1;
    end
  end

  assign o_busy_vec = pend;

endmodule

// File: rtl/riscv_register_file_mp.sv
// Parametrised multi-port RV32 integer register file with a pending scoreboard.
// Ports:
//   i_clk, i_rstn            clock; asynchronous active-low reset clears contents and scoreboard
//   i_rd_addr/o_rd_data      NRD packed read ports with combinational reads
//   o_rd_busy                pending bit of each read address
//   i_wr_en/addr/data/clr    NWR packed write ports; the highest index wins on a conflict
//   i_iss_valid, i_iss_rd    issue marking i_iss_rd pending
//   o_iss_ready              issue may proceed because there is no WAW hazard
//   o_busy_vec               full scoreboard
// Build option: with RISCV_REGFILE_BYPASS_EN defined, read ports forward
// same-cycle write data. A read port also shows not-busy when the winning
// write port clears the pending bit.
module riscv_register_file_mp
  import riscv_register_file_mp_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned AW    = RF_AW,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic [NWR-1:0]      i_wr_clr,
  input  logic                i_iss_valid,
  input  logic [AW-1:0]       i_iss_rd,
  output logic                o_iss_ready,
  output logic [NREGS-1:0]    o_busy_vec
);

  localparam int unsigned IW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_vec;

  riscv_regfile_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW),
    .NWR  (NWR)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_clr   (i_wr_clr),
    .i_iss_valid(i_iss_valid),
    .i_iss_rd   (i_iss_rd),
    .o_iss_ready(o_iss_ready),
    .o_busy_vec (busy_vec)
  );

  assign o_busy_vec = busy_vec;

  // x0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && rf_addr_ok(32'(i_wr_addr[j*AW +: AW]), NREGS))
          regs[i_wr_addr[j*AW +: IW]] <= i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (rf_addr_ok(32'(i_rd_addr[k*AW +: AW]), NREGS)) begin
        o_rd_data[k*XLEN +: XLEN] = regs[i_rd_addr[k*AW +: IW]];
        o_rd_busy[k]              = busy_vec[i_rd_addr[k*AW +: IW]];
`ifdef RISCV_REGFILE_BYPASS_EN
        // A legal read address makes every equal write address legal too.
        for (int unsigned j = 0; j < NWR; j++) begin
          if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr[k*AW +: AW])) begin
            o_rd_data[k*XLEN +: XLEN] = i_wr_data[j*XLEN +: XLEN];
            o_rd_busy[k]              = busy_vec[i_rd_addr[k*AW +: IW]] & ~i_wr_clr[j];
          end
        end
`endif
      end
    end
  end

endmodule
